mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the IF port (instruction fetch) and the MEM port (load/store) of the 5-stage pipeline.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_inst_line_buf.sv | 66 ++++++
 rtl/mem_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//  Shared definitions for the IF/MEM memory port arbiter: FSM state codes,
//  grant encodings and the word-offset width that splits an address into
//  line tag and byte offset.
//  Optional feature macro used by the arbiter: ARB_INST_BUF_EN.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_INST_BUSY = 2'd1,
    ARB_DATA_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  // Addresses are byte addresses of 32-bit words; the tag drops the offset.
  localparam int unsigned TAG_LSB = 2;

endpackage

// File: rtl/mem_port_arbiter_inst_line_buf.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_inst_line_buf
//  One-entry instruction buffer used by mem_port_arbiter when ARB_INST_BUF_EN
//  is defined (the whole module is compiled only in that build).
//  Ports:
//   clk, rst          clock, asynchronous active-high reset (clears valid)
//   lookup_tag        tag of the current fetch address
//   hit, hit_data     entry valid and tag match; buffered instruction
//   fill_en/tag/data  load the entry (every IF memory ack)
//   inval_en/tag      store completing; drops the entry on tag match
// -----------------------------------------------------------------------------
`ifdef ARB_INST_BUF_EN
module mem_port_arbiter_inst_line_buf
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-TAG_LSB-1:0] lookup_tag,
  output logic                      hit,
  output logic [DATA_W-1:0]         hit_data,
  input  logic                      fill_en,
  input  logic [ADDR_W-TAG_LSB-1:0] fill_tag,
  input  logic [DATA_W-1:0]         fill_data,
  input  logic                      inval_en,
  input  logic [ADDR_W-TAG_LSB-1:0] inval_tag
);

  logic [ADDR_W-TAG_LSB-1:0] tag_q, tag_d;
  logic [DATA_W-1:0]         data_q, data_d;
  logic                      valid_q, valid_d;

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (fill_en) begin
      tag_d   = fill_tag;
      data_d  = fill_data;
      valid_d = 1'b1;
    end
    // A store landing on the buffered word makes the copy stale.
    if (inval_en && valid_q && (inval_tag == tag_q)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign hit      = valid_q && (tag_q == lookup_tag);
  assign hit_data = data_q;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//  Shares one single-ported memory between the IF (fetch) and MEM (load/store)
//  pipeline ports. One transaction at a time, round-robin on contention,
//  per-port stall until served, returned data held until the stage advances.
//  Optional: ARB_INST_BUF_EN adds a one-entry instruction buffer that serves
//  repeated fetches of the same word in zero cycles without a memory access.
//  Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   inst_ren/inst_addr/if_en       IF request, address, stage advance
//   inst_data/inst_stall           fetched instruction, IF stall
//   mem_ren/mem_wen/mem_addr/
//   mem_dout/mem_en                MEM load/store request, data, advance
//   mem_din/mem_stall              load data, MEM stall
//   ram_cs/ram_we/ram_addr/
//   ram_wdata (registered)         memory command
//   ram_rdata/ram_ack              memory read data / completion
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ren,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              if_en,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_stall,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_en,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_stall,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);
  import mem_port_arbiter_pkg::*;

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              inst_served_q, inst_served_d;
  logic              mem_served_q, mem_served_d;
  logic [DATA_W-1:0] inst_hold_q, inst_hold_d;
  logic [DATA_W-1:0] mem_hold_q, mem_hold_d;

  logic              inst_ack, data_ack;
  logic              inst_take, mem_take, load_take;
  logic              if_pend, mem_pend;
  logic              inst_hit;
  logic [DATA_W-1:0] inst_hit_data;

  // Raw acks belong to whichever port owns the transaction in flight; they
  // only count for the port if its request is still up (not flushed).
  assign inst_ack  = (state_q == ARB_INST_BUSY) && ram_ack;
  assign data_ack  = (state_q == ARB_DATA_BUSY) && ram_ack;
  assign inst_take = inst_ack && inst_ren;
  assign mem_take  = data_ack && (mem_ren || mem_wen);
  assign load_take = mem_take && !ram_we_q;

`ifdef ARB_INST_BUF_EN
  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;

  mem_port_arbiter_inst_line_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (inst_addr[ADDR_W-1:TAG_LSB]),
    .hit        (buf_hit),
    .hit_data   (buf_data),
    .fill_en    (inst_ack),
    .fill_tag   (ram_addr_q[ADDR_W-1:TAG_LSB]),
    .fill_data  (ram_rdata),
    .inval_en   (data_ack && ram_we_q),
    .inval_tag  (ram_addr_q[ADDR_W-1:TAG_LSB])
  );

  // A hit is only taken while the port is idle, so it never races a fill.
  assign inst_hit      = (state_q == ARB_IDLE) && inst_ren && !inst_served_q && buf_hit;
  assign inst_hit_data = buf_data;
`else
  assign inst_hit      = 1'b0;
  assign inst_hit_data = '0;
`endif

  // A buffer hit satisfies IF without the memory, leaving it free for MEM.
  assign if_pend  = inst_ren && !inst_served_q && !inst_hit;
  assign mem_pend = (mem_ren || mem_wen) && !mem_served_q;

  // Next-state / command register logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ram_cs_d     = ram_cs_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (mem_pend && (!if_pend || (last_grant_q == GRANT_IF))) begin
          state_d      = ARB_DATA_BUSY;
          last_grant_d = GRANT_MEM;
          ram_cs_d     = 1'b1;
          ram_we_d     = mem_wen;
          ram_addr_d   = mem_addr;
          ram_wdata_d  = mem_dout;
        end else if (if_pend) begin
          state_d      = ARB_INST_BUSY;
          last_grant_d = GRANT_IF;
          ram_cs_d     = 1'b1;
          ram_we_d     = 1'b0;
          ram_addr_d   = inst_addr;
        end
      end
      ARB_INST_BUSY, ARB_DATA_BUSY: begin
        if (ram_ack) begin
          state_d  = ARB_IDLE;
          ram_cs_d = 1'b0;
          ram_we_d = 1'b0;
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        ram_cs_d = 1'b0;
        ram_we_d = 1'b0;
      end
    endcase
  end

  // Served flags and hold registers; stage enable wins over a same-edge set.
  always_comb begin
    inst_served_d = (inst_served_q || inst_take || inst_hit) && !if_en;
    mem_served_d  = (mem_served_q || mem_take) && !mem_en;
    inst_hold_d   = inst_hold_q;
    if (inst_take) begin
      inst_hold_d = ram_rdata;
    end else if (inst_hit) begin
      inst_hold_d = inst_hit_data;
    end
    mem_hold_d = load_take ? ram_rdata : mem_hold_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      last_grant_q  <= GRANT_IF;
      ram_cs_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      inst_served_q <= 1'b0;
      mem_served_q  <= 1'b0;
      inst_hold_q   <= '0;
      mem_hold_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      ram_cs_q      <= ram_cs_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      inst_served_q <= inst_served_d;
      mem_served_q  <= mem_served_d;
      inst_hold_q   <= inst_hold_d;
      mem_hold_q    <= mem_hold_d;
    end
  end

  // Outputs: stalls drop and data bypasses the hold registers in the ack cycle.
  always_comb begin
    inst_stall = inst_ren && !inst_served_q && !inst_take && !inst_hit;
    mem_stall  = (mem_ren || mem_wen) && !mem_served_q && !mem_take;
    inst_data  = inst_hold_q;
    if (inst_take) begin
      inst_data = ram_rdata;
    end else if (inst_hit) begin
      inst_data = inst_hit_data;
    end
    mem_din = load_take ? ram_rdata : mem_hold_q;
  end

  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_ren = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        if_en = 1'b0;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_dout = '0;
  logic        mem_en = 1'b0;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        ram_cs;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ack = 1'b0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_ren   (inst_ren),
    .inst_addr  (inst_addr),
    .if_en      (if_en),
    .inst_data  (inst_data),
    .inst_stall (inst_stall),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_en     (mem_en),
    .mem_din    (mem_din),
    .mem_stall  (mem_stall),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_ack    (ram_ack)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Scoreboard of memory transactions expected to complete, in order.
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;
  txn_t exp_q[$];

  task automatic push_txn(input logic [31:0] a, input logic w, input logic [31:0] d);
    txn_t t;
    t.addr = a; t.we = w; t.wdata = d;
    exp_q.push_back(t);
  endtask

  // Memory model: word store plus an address-derived default pattern.
  logic [31:0] mem [int];
  int          mem_lat = 0;
  int          wait_cnt = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a ^ 32'hC0DE_0000;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ram_ack   = 1'b0;
      ram_rdata = 32'hBAD0_BAD0;
      if (ram_cs && !rst) begin
        if (wait_cnt >= mem_lat) begin
          txn_t t;
          ram_ack  = 1'b1;
          wait_cnt = 0;
          if (ram_we) mem[int'(ram_addr)] = ram_wdata;
          else        ram_rdata = mem_rd(ram_addr);
          $display("txn addr=%08h we=%0b wdata=%08h rdata=%08h", ram_addr, ram_we, ram_wdata, ram_rdata);
          if (exp_q.size() == 0) begin
            check_eq("txn_unexpected", 32'd1, 32'd0);
          end else begin
            t = exp_q.pop_front();
            check_eq("txn_addr", ram_addr, t.addr);
            check_eq("txn_we", {31'd0, ram_we}, {31'd0, t.we});
            if (t.we) check_eq("txn_wdata", ram_wdata, t.wdata);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Drive point: 2 time units after the active edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Count cycles the port stalls, starting from an already-sampled cycle.
  task automatic wait_release(input bit is_mem, output int n);
    n = 0;
    while ((is_mem ? mem_stall : inst_stall) && n < 50) begin
      n++;
      step();
      #4;
    end
    if (n >= 50) check_eq("release_timeout", 32'd1, 32'd0);
  endtask

  task automatic release_ports();
    step(); inst_ren = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; if_en = 1'b1; mem_en = 1'b1;
    step(); if_en = 1'b0; mem_en = 1'b0;
  endtask

  // Simultaneous fetch and load; load must win (last grant was IF).
  task automatic contention(input logic [31:0] ia, input logic [31:0] ma, input string tag);
    int  c, mc, ic;
    bit  md, id;
    c = 0; mc = -1; ic = -1; md = 0; id = 0;
    push_txn(ma, 1'b0, 32'd0);
    push_txn(ia, 1'b0, 32'd0);
    step();
    inst_ren = 1'b1; inst_addr = ia; mem_ren = 1'b1; mem_addr = ma;
    #4;
    while (!(md && id) && c < 50) begin
      if (!md && !mem_stall) begin
        md = 1; mc = c;
        check_eq({tag, "_mem_din"}, mem_din, mem_rd(ma));
      end
      if (!id && !inst_stall) begin
        id = 1; ic = c;
        check_eq({tag, "_inst_data"}, inst_data, mem_rd(ia));
      end
      if (!(md && id)) begin
        step(); #4; c++;
      end
    end
    check_eq({tag, "_mem_cycle"}, mc, 32'd2);
    check_eq({tag, "_inst_cycle"}, ic, 32'd5);
    release_ports();
  endtask

  initial begin
    int n;
    logic [31:0] prev;

    // Reset state.
    #3;
    check_eq("rst_ram_cs", {31'd0, ram_cs}, 32'd0);
    check_eq("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check_eq("rst_ram_addr", ram_addr, 32'd0);
    check_eq("rst_ram_wdata", ram_wdata, 32'd0);
    check_eq("rst_inst_data", inst_data, 32'd0);
    check_eq("rst_mem_din", mem_din, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Lone fetch, ack two cycles after ram_cs.
    mem[32'h10] = 32'h2008_0005;
    mem[32'h14] = 32'h3333_4444;
    mem_lat = 2;
    push_txn(32'h10, 1'b0, 32'd0);
    step();
    inst_ren = 1'b1; inst_addr = 32'h10;
    #4;
    check_eq("fetch_cs_cycle0", {31'd0, ram_cs}, 32'd0);
    wait_release(1'b0, n);
    check_eq("fetch_stall_cycles", n, 32'd3);
    check_eq("fetch_ack_data", inst_data, 32'h2008_0005);
    check_eq("fetch_ack_seen", {31'd0, ram_ack}, 32'd1);
    step();
    #4;
    check_eq("fetch_held_stall", {31'd0, inst_stall}, 32'd0);
    check_eq("fetch_held_data", inst_data, 32'h2008_0005);
    check_eq("fetch_no_reissue", {31'd0, ram_cs}, 32'd0);
    release_ports();

    // Contention twice: MEM first both times, last_grant ends as IF.
    mem_lat = 1;
    contention(32'h14, 32'h100, "cont1");
    contention(32'h18, 32'h108, "cont2");

    // Store with MEM stage held for four cycles after the ack.
    mem_lat = 0;
    prev = mem_rd(32'h108);
    push_txn(32'h104, 1'b1, 32'hDEAD_BEEF);
    step();
    mem_wen = 1'b1; mem_addr = 32'h104; mem_dout = 32'hDEAD_BEEF;
    #4;
    wait_release(1'b1, n);
    check_eq("store_stall_cycles", n, 32'd1);
    check_eq("store_din_ack", mem_din, prev);
    for (int i = 0; i < 4; i++) begin
      step();
      #4;
      check_eq("store_hold_stall", {31'd0, mem_stall}, 32'd0);
      check_eq("store_hold_cs", {31'd0, ram_cs}, 32'd0);
    end
    check_eq("store_din_kept", mem_din, prev);
    release_ports();

    // Fetch withdrawn while busy.
    mem_lat = 3;
    push_txn(32'h20, 1'b0, 32'd0);
    step();
    inst_ren = 1'b1; inst_addr = 32'h20;
    step();
    #4;
    check_eq("flush_busy", {31'd0, ram_cs}, 32'd1);
    step();
    inst_ren = 1'b0;
    #4;
    check_eq("flush_stall", {31'd0, inst_stall}, 32'd0);
    n = 0;
    while (ram_cs && n < 20) begin
      if (ram_ack) check_eq("flush_ack_ignored", inst_data, mem_rd(32'h18));
      step(); #4; n++;
    end
    if (n >= 20) check_eq("flush_timeout", 32'd1, 32'd0);
    push_txn(32'h24, 1'b0, 32'd0);
    step();
    inst_ren = 1'b1; inst_addr = 32'h24;
    #4;
    check_eq("refetch_stalls", {31'd0, inst_stall}, 32'd1);
    wait_release(1'b0, n);
    check_eq("refetch_cycles", n, 32'd4);
    check_eq("refetch_data", inst_data, mem_rd(32'h24));
    release_ports();

    // Reset in the middle of a load.
    mem_lat = 10;
    step();
    mem_ren = 1'b1; mem_addr = 32'h200;
    step(); step();
    #4;
    check_eq("rst_mid_busy", {31'd0, ram_cs}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_cs", {31'd0, ram_cs}, 32'd0);
    check_eq("rst_mid_mem_din", mem_din, 32'd0);
    check_eq("rst_mid_inst_data", inst_data, 32'd0);
    check_eq("rst_mid_mem_stall", {31'd0, mem_stall}, 32'd1);
    check_eq("rst_mid_inst_stall0", {31'd0, inst_stall}, 32'd0);
    inst_ren = 1'b1;
    #1;
    check_eq("rst_mid_inst_stall1", {31'd0, inst_stall}, 32'd1);
    step();
    rst = 1'b0; mem_ren = 1'b0; inst_ren = 1'b0;
    #4;
    check_eq("rst_after_cs", {31'd0, ram_cs}, 32'd0);
    step();

`ifdef ARB_INST_BUF_EN
    // Buffer fill, zero-cycle hit, store invalidation, miss.
    mem_lat = 1;
    push_txn(32'h14, 1'b0, 32'd0);
    step();
    inst_ren = 1'b1; inst_addr = 32'h14;
    #4;
    wait_release(1'b0, n);
    check_eq("buf_fill_data", inst_data, 32'h3333_4444);
    release_ports();
    step();
    inst_ren = 1'b1; inst_addr = 32'h14;
    #4;
    check_eq("buf_hit_stall", {31'd0, inst_stall}, 32'd0);
    check_eq("buf_hit_data", inst_data, 32'h3333_4444);
    check_eq("buf_hit_cs", {31'd0, ram_cs}, 32'd0);
    step();
    inst_ren = 1'b0; if_en = 1'b1;
    #4;
    check_eq("buf_hit_no_access", {31'd0, ram_cs}, 32'd0);
    step();
    if_en = 1'b0;
    push_txn(32'h14, 1'b1, 32'h5555_6666);
    step();
    mem_wen = 1'b1; mem_addr = 32'h14; mem_dout = 32'h5555_6666;
    #4;
    wait_release(1'b1, n);
    release_ports();
    push_txn(32'h14, 1'b0, 32'd0);
    step();
    inst_ren = 1'b1; inst_addr = 32'h14;
    #4;
    check_eq("buf_miss_stall", {31'd0, inst_stall}, 32'd1);
    wait_release(1'b0, n);
    check_eq("buf_miss_data", inst_data, 32'h5555_6666);
    release_ports();
`endif

    step(); step();
    check_eq("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
